// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the posted-write store buffer.
// Entry layout and pointer/count widths live here so the top and the match search agree.
package store_buffer_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_PTR_W  = $clog2(SB_DEPTH);
    localparam int SB_CNT_W  = SB_PTR_W + 1;

    typedef logic [SB_PTR_W-1:0]  ptr_t;
    typedef logic [SB_CNT_W-1:0]  cnt_t;
    typedef logic [SB_ADDR_W-1:0] addr_t;
    typedef logic [SB_DATA_W-1:0] data_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
        data_t data;
    } sb_entry_t;

    // Pointers wrap modulo SB_DEPTH because SB_DEPTH is a power of two.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side and DataMemory-side signals of the store buffer.
// The slave modport is the buffer's view; master is the pipeline/memory environment.
interface store_buffer_if;
    import store_buffer_pkg::*;

    logic  memRead_i;
    logic  memWrite_i;
    addr_t addr_i;
    data_t writeData_i;
    logic  fence_i;
    logic  dmReady_i;
    data_t dmReadData_i;
    logic  stall_o;
    data_t loadData_o;
    logic  dmRead_o;
    logic  dmWrite_o;
    addr_t dmAddr_o;
    data_t dmData_o;

    modport slave (
        input  memRead_i, memWrite_i, addr_i, writeData_i, fence_i,
        input  dmReady_i, dmReadData_i,
        output stall_o, loadData_o, dmRead_o, dmWrite_o, dmAddr_o, dmData_o
    );

    modport master (
        output memRead_i, memWrite_i, addr_i, writeData_i, fence_i,
        output dmReady_i, dmReadData_i,
        input  stall_o, loadData_o, dmRead_o, dmWrite_o, dmAddr_o, dmData_o
    );

endinterface

// File: rtl/store_buffer_sb_match.sv
// Youngest-match search over the queued stores, oldest (head) to youngest.
// Purely combinational; a later hit in scan order overrides an earlier one.
module sb_match
    import store_buffer_pkg::*;
(
    input  sb_entry_t entries_i [SB_DEPTH],
    input  ptr_t      head_i,
    input  cnt_t      count_i,
    input  addr_t     addr_i,
    output logic      hit_o,
    output data_t     data_o
);

    ptr_t idx;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = head_i;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head_i + ptr_t'(i);
            if ((cnt_t'(i) < count_i) && entries_i[idx].valid &&
                (entries_i[idx].addr == addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between EX/MEM and DataMemory: queues stores, drains them on
// load-free cycles, and forwards the youngest queued data to matching loads.
module store_buffer
    import store_buffer_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    store_buffer_if.slave  bus
);

    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;
    cnt_t             count_q, count_d;
    logic [SB_DEPTH-1:0] valid_q, valid_d;
    logic             fwd_hit_q, fwd_hit_d;
    data_t            fwd_data_q, fwd_data_d;

    addr_t            addr_mem_q [SB_DEPTH];
    data_t            data_mem_q [SB_DEPTH];
    sb_entry_t        entries    [SB_DEPTH];

    logic             drain;
    logic             push;
    logic             stall;
    logic             match_hit;
    data_t            match_data;

    always_comb begin
        for (int i = 0; i < SB_DEPTH; i++) begin
            entries[i] = '{valid: valid_q[i], addr: addr_mem_q[i], data: data_mem_q[i]};
        end
    end

    sb_match u_match (
        .entries_i (entries),
        .head_i    (head_q),
        .count_i   (count_q),
        .addr_i    (bus.addr_i),
        .hit_o     (match_hit),
        .data_o    (match_data)
    );

    // One memory access per cycle: a load always wins over draining the head entry.
    always_comb begin
        drain = !bus.memRead_i && (count_q != '0) && bus.dmReady_i;
        stall = (bus.memWrite_i && (count_q == cnt_t'(SB_DEPTH)) && !drain) ||
                (bus.fence_i && (count_q != '0));
        push  = bus.memWrite_i && !stall;

        bus.stall_o    = stall;
        bus.dmRead_o   = bus.memRead_i;
        bus.dmWrite_o  = drain;
        bus.dmAddr_o   = drain ? addr_mem_q[head_q] : bus.addr_i;
        bus.dmData_o   = data_mem_q[head_q];
        bus.loadData_o = fwd_hit_q ? fwd_data_q : bus.dmReadData_i;
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        valid_d    = valid_q;
        fwd_hit_d  = bus.memRead_i && match_hit;
        fwd_data_d = (bus.memRead_i && match_hit) ? match_data : '0;

        // Clear before set: when full, push reuses the slot being drained.
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = ptr_inc(head_q);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = ptr_inc(tail_q);
        end

        unique case ({push, drain})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // NOTE: the payload array is not reset; valid bits and count gate every use of it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem_q[tail_q] <= bus.addr_i;
            data_mem_q[tail_q] <= bus.writeData_i;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: a vector table for steady-state behaviour
// plus hand-written sequences for fence, load miss and mid-stream reset.
module tb_store_buffer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    store_buffer_if sb_if ();

    store_buffer dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fence;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        chk_ld;
        logic [31:0] e_ld;
    } vec_t;

    vec_t vecs [26];

    function automatic vec_t mk(input logic rd, wr, input logic [31:0] addr, wdata,
                                input logic fence, rdy, input logic [31:0] rdata,
                                input logic e_stall, e_rd, e_wr,
                                input logic [31:0] e_addr, e_data,
                                input logic chk_ld, input logic [31:0] e_ld);
        vec_t v;
        v.rd = rd;         v.wr = wr;       v.addr = addr;     v.wdata = wdata;
        v.fence = fence;   v.rdy = rdy;     v.rdata = rdata;
        v.e_stall = e_stall; v.e_rd = e_rd; v.e_wr = e_wr;
        v.e_addr = e_addr; v.e_data = e_data;
        v.chk_ld = chk_ld; v.e_ld = e_ld;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs on the falling edge, then settle before sampling.
    task automatic drive(input logic rd, wr, input logic [31:0] addr, wdata,
                         input logic fence, rdy, input logic [31:0] rdata);
        @(negedge clk);
        sb_if.memRead_i    = rd;
        sb_if.memWrite_i   = wr;
        sb_if.addr_i       = addr;
        sb_if.writeData_i  = wdata;
        sb_if.fence_i      = fence;
        sb_if.dmReady_i    = rdy;
        sb_if.dmReadData_i = rdata;
        #2;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //       rd wr addr   wdata  f rdy rdata     stall drd dwr daddr  ddata  chk ld
        vecs[0]  = mk(0, 1, 32'h5,  32'h11, 0, 1, 0,        0, 0, 0, 32'h5,  0,      0, 0);
        vecs[1]  = mk(0, 0, 32'h0,  0,      0, 1, 0,        0, 0, 1, 32'h5,  32'h11, 0, 0);
        vecs[2]  = mk(0, 0, 32'h7,  0,      0, 1, 0,        0, 0, 0, 32'h7,  0,      0, 0);
        vecs[3]  = mk(0, 1, 32'h8,  32'hAA, 0, 0, 0,        0, 0, 0, 32'h8,  0,      0, 0);
        vecs[4]  = mk(0, 1, 32'h8,  32'hBB, 0, 0, 0,        0, 0, 0, 32'h8,  0,      0, 0);
        vecs[5]  = mk(1, 0, 32'h8,  0,      0, 0, 32'h1234, 0, 1, 0, 32'h8,  0,      0, 0);
        vecs[6]  = mk(0, 0, 32'h0,  0,      0, 0, 32'h5555, 0, 0, 0, 32'h0,  0,      1, 32'hBB);
        vecs[7]  = mk(1, 0, 32'h3,  0,      0, 1, 32'h1,    0, 1, 0, 32'h3,  0,      0, 0);
        vecs[8]  = mk(0, 0, 32'h0,  0,      0, 0, 32'hCAFE, 0, 0, 0, 32'h0,  0,      1, 32'hCAFE);
        vecs[9]  = mk(0, 0, 32'h0,  0,      0, 1, 0,        0, 0, 1, 32'h8,  32'hAA, 0, 0);
        vecs[10] = mk(0, 0, 32'h0,  0,      0, 1, 0,        0, 0, 1, 32'h8,  32'hBB, 0, 0);
        vecs[11] = mk(0, 0, 32'h9,  0,      0, 1, 0,        0, 0, 0, 32'h9,  0,      0, 0);
        vecs[12] = mk(0, 1, 32'h10, 32'h1,  0, 0, 0,        0, 0, 0, 32'h10, 0,      0, 0);
        vecs[13] = mk(0, 1, 32'h11, 32'h2,  0, 0, 0,        0, 0, 0, 32'h11, 0,      0, 0);
        vecs[14] = mk(0, 1, 32'h12, 32'h3,  0, 0, 0,        0, 0, 0, 32'h12, 0,      0, 0);
        vecs[15] = mk(0, 1, 32'h13, 32'h4,  0, 0, 0,        0, 0, 0, 32'h13, 0,      0, 0);
        vecs[16] = mk(0, 1, 32'h14, 32'h5,  0, 0, 0,        1, 0, 0, 32'h14, 0,      0, 0);
        vecs[17] = mk(0, 1, 32'h14, 32'h5,  0, 1, 0,        0, 0, 1, 32'h10, 32'h1,  0, 0);
        vecs[18] = mk(1, 0, 32'h14, 0,      0, 0, 0,        0, 1, 0, 32'h14, 0,      0, 0);
        vecs[19] = mk(0, 0, 32'h0,  0,      0, 0, 0,        0, 0, 0, 32'h0,  0,      1, 32'h5);
        vecs[20] = mk(0, 1, 32'h15, 32'h6,  0, 0, 0,        1, 0, 0, 32'h15, 0,      0, 0);
        vecs[21] = mk(0, 0, 32'h0,  0,      0, 1, 0,        0, 0, 1, 32'h11, 32'h2,  0, 0);
        vecs[22] = mk(0, 0, 32'h0,  0,      0, 1, 0,        0, 0, 1, 32'h12, 32'h3,  0, 0);
        vecs[23] = mk(0, 0, 32'h0,  0,      0, 1, 0,        0, 0, 1, 32'h13, 32'h4,  0, 0);
        vecs[24] = mk(0, 0, 32'h0,  0,      0, 1, 0,        0, 0, 1, 32'h14, 32'h5,  0, 0);
        vecs[25] = mk(0, 0, 32'h2,  0,      0, 1, 0,        0, 0, 0, 32'h2,  0,      0, 0);

        // Power-on reset state.
        rst_n = 1'b0;
        sb_if.memRead_i    = 1'b0;
        sb_if.memWrite_i   = 1'b0;
        sb_if.addr_i       = '0;
        sb_if.writeData_i  = '0;
        sb_if.fence_i      = 1'b0;
        sb_if.dmReady_i    = 1'b1;
        sb_if.dmReadData_i = 32'h99;
        repeat (2) @(negedge clk);
        #2;
        check("reset stall_o",    sb_if.stall_o,    0);
        check("reset dmWrite_o",  sb_if.dmWrite_o,  0);
        check("reset dmRead_o",   sb_if.dmRead_o,   0);
        check("reset loadData_o", sb_if.loadData_o, 32'h99);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                  vecs[i].fence, vecs[i].rdy, vecs[i].rdata);
            check($sformatf("v%0d stall_o", i),   sb_if.stall_o,   vecs[i].e_stall);
            check($sformatf("v%0d dmRead_o", i),  sb_if.dmRead_o,  vecs[i].e_rd);
            check($sformatf("v%0d dmWrite_o", i), sb_if.dmWrite_o, vecs[i].e_wr);
            check($sformatf("v%0d dmAddr_o", i),  sb_if.dmAddr_o,  vecs[i].e_addr);
            if (vecs[i].e_wr)
                check($sformatf("v%0d dmData_o", i), sb_if.dmData_o, vecs[i].e_data);
            if (vecs[i].chk_ld)
                check($sformatf("v%0d loadData_o", i), sb_if.loadData_o, vecs[i].e_ld);
        end

        // Fence with two queued stores: stall holds until count reaches zero.
        drive(0, 1, 32'h20, 32'hA, 0, 0, 0);
        drive(0, 1, 32'h21, 32'hB, 0, 0, 0);
        drive(0, 0, 32'h0,  0,     1, 1, 0);
        check("fence c1 stall_o",   sb_if.stall_o,   1);
        check("fence c1 dmAddr_o",  sb_if.dmAddr_o,  32'h20);
        check("fence c1 dmData_o",  sb_if.dmData_o,  32'hA);
        drive(0, 0, 32'h0,  0,     1, 1, 0);
        check("fence c2 stall_o",   sb_if.stall_o,   1);
        check("fence c2 dmAddr_o",  sb_if.dmAddr_o,  32'h21);
        check("fence c2 dmData_o",  sb_if.dmData_o,  32'hB);
        drive(0, 0, 32'h0,  0,     1, 1, 0);
        check("fence c3 stall_o",   sb_if.stall_o,   0);
        check("fence c3 dmWrite_o", sb_if.dmWrite_o, 0);

        // Load miss while the buffer holds a different address; head must not drain.
        drive(0, 1, 32'h4, 32'h44, 0, 0, 0);
        drive(1, 0, 32'h3, 0,      0, 1, 32'h0);
        check("miss dmRead_o",  sb_if.dmRead_o,  1);
        check("miss dmWrite_o", sb_if.dmWrite_o, 0);
        drive(0, 0, 32'h0, 0,      0, 0, 32'h77);
        check("miss loadData_o", sb_if.loadData_o, 32'h77);
        drive(0, 0, 32'h0, 0,      0, 1, 0);
        check("miss drain dmAddr_o", sb_if.dmAddr_o, 32'h4);
        check("miss drain dmData_o", sb_if.dmData_o, 32'h44);
        drive(0, 0, 32'h0, 0,      0, 1, 0);
        check("miss empty dmWrite_o", sb_if.dmWrite_o, 0);

        // Mid-stream reset with three queued stores: nothing may reach DataMemory.
        drive(0, 1, 32'h30, 32'h3, 0, 0, 0);
        drive(0, 1, 32'h31, 32'h4, 0, 0, 0);
        drive(0, 1, 32'h32, 32'h5, 0, 0, 0);
        drive(0, 0, 32'h0,  0,     1, 1, 0);
        check("pre-reset stall_o",   sb_if.stall_o,   1);
        check("pre-reset dmWrite_o", sb_if.dmWrite_o, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset stall_o",   sb_if.stall_o,   0);
        check("async reset dmWrite_o", sb_if.dmWrite_o, 0);
        drive(0, 0, 32'h0, 0, 0, 1, 32'h66);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 32'h0, 0, 0, 1, 32'h66);
            check($sformatf("post-reset c%0d dmWrite_o", c), sb_if.dmWrite_o, 0);
        end
        check("post-reset loadData_o", sb_if.loadData_o, 32'h66);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
